// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
// pipe_ctrl_t is the standard two-bit control bundle; pipe_occ_w sizes occ_o.
package pipe_pkg;

    localparam int PIPE_RD_W      = 5;
    localparam int PIPE_CTRL_W    = 2;
    localparam int PIPE_MAX_DEPTH = 4;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } pipe_ctrl_t;

    // Room for DEPTH slots plus an optional skid entry.
    function automatic int pipe_occ_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline register slot: valid bit plus ctrl/data/rd payload.
// A slot not reloaded while its contents leave becomes a bubble with stale payload.
module pipe_slot #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              leave_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [RD_W-1:0]   rd_o
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [RD_W-1:0]   r_rd;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_rd    <= '0;
        end else begin
            if (clear_i) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= load_i | (r_valid & ~leave_i);
            end
            // Payload is left untouched on clear; only the valid bit matters.
            if (load_i && !clear_i) begin
                r_ctrl <= ctrl_i;
                r_data <= data_i;
                r_rd   <= rd_i;
            end
        end
    end

    assign valid_o = r_valid;
    assign ctrl_o  = r_ctrl;
    assign data_o  = r_data;
    assign rd_o    = r_rd;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: DEPTH slots with valid/ready stall, flush and occupancy.
// Define PIPE_SKID_EN to add an input skid entry and make ready_o a registered signal.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int RD_W   = PIPE_RD_W,
    parameter int DEPTH  = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic [RD_W-1:0]              rd_i,
    input  logic                         flush_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [DATA_W-1:0]            data_o,
    output logic [RD_W-1:0]              rd_o,
    output logic [pipe_occ_w(DEPTH)-1:0] occ_o
);

    localparam int OCC_W = pipe_occ_w(DEPTH);

    logic              w_slot_v  [DEPTH];
    logic [CTRL_W-1:0] w_ctrl    [DEPTH];
    logic [DATA_W-1:0] w_data    [DEPTH];
    logic [RD_W-1:0]   w_rd      [DEPTH];
    logic [CTRL_W-1:0] w_in_ctrl [DEPTH];
    logic [DATA_W-1:0] w_in_data [DEPTH];
    logic [RD_W-1:0]   w_in_rd   [DEPTH];

    logic [DEPTH-1:0]  w_v;
    logic [DEPTH-1:0]  w_load;
    logic [DEPTH:0]    w_space;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_load0;
    logic [OCC_W-1:0]  r_occ;

    always_comb begin
        w_v = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_v[k] = w_slot_v[k];
        end
    end

    // w_space[k]: slot k is empty or its contents move on this cycle.
    // Evaluated from the output end so each bit sees its successor.
    always_comb begin
        w_space        = '0;
        w_space[DEPTH] = ready_i;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            w_space[DEPTH-1-j] = ~w_v[DEPTH-1-j] | w_space[DEPTH-j];
        end
    end

    always_comb begin
        w_load    = '0;
        w_load[0] = w_load0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_load[k] = w_v[k-1] & w_space[k];
        end
    end

    assign w_out_xfer = w_v[DEPTH-1] & ready_i;

`ifdef PIPE_SKID_EN
    logic              w_skid_v;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [RD_W-1:0]   w_skid_rd;

    // Skid catches an accepted entry that slot 0 cannot take, and drains first.
    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_in_xfer & ~w_space[0]),
        .leave_i (w_space[0]),
        .clear_i (flush_i),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .rd_i    (rd_i),
        .valid_o (w_skid_v),
        .ctrl_o  (w_skid_ctrl),
        .data_o  (w_skid_data),
        .rd_o    (w_skid_rd)
    );

    assign ready_o      = ~w_skid_v;
    assign w_in_xfer    = valid_i & ~w_skid_v;
    assign w_load0      = (w_skid_v | w_in_xfer) & w_space[0];
    assign w_in_ctrl[0] = w_skid_v ? w_skid_ctrl : ctrl_i;
    assign w_in_data[0] = w_skid_v ? w_skid_data : data_i;
    assign w_in_rd[0]   = w_skid_v ? w_skid_rd   : rd_i;
`else
    assign ready_o      = w_space[0];
    assign w_in_xfer    = valid_i & w_space[0];
    assign w_load0      = w_in_xfer;
    assign w_in_ctrl[0] = ctrl_i;
    assign w_in_data[0] = data_i;
    assign w_in_rd[0]   = rd_i;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g > 0) begin : g_link
            assign w_in_ctrl[g] = w_ctrl[g-1];
            assign w_in_data[g] = w_data[g-1];
            assign w_in_rd[g]   = w_rd[g-1];
        end

        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W),
            .RD_W   (RD_W)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (w_load[g]),
            .leave_i (w_space[g+1]),
            .clear_i (flush_i),
            .ctrl_i  (w_in_ctrl[g]),
            .data_i  (w_in_data[g]),
            .rd_i    (w_in_rd[g]),
            .valid_o (w_slot_v[g]),
            .ctrl_o  (w_ctrl[g]),
            .data_o  (w_data[g]),
            .rd_o    (w_rd[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
        end
    end

    assign valid_o = w_v[DEPTH-1];
    assign ctrl_o  = w_v[DEPTH-1] ? w_ctrl[DEPTH-1] : '0;
    assign data_o  = w_data[DEPTH-1];
    assign rd_o    = w_rd[DEPTH-1];
    assign occ_o   = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH 1..4 instances share one randomized input stream;
// an entry/position model predicts every output each cycle (honours PIPE_SKID_EN).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int NDUT = PIPE_MAX_DEPTH;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  ctrl_i = '0;
    logic [63:0] data_i = '0;
    logic [4:0]  rd_i = '0;

    logic        o_valid [NDUT];
    logic        o_ready [NDUT];
    logic [1:0]  o_ctrl  [NDUT];
    logic [63:0] o_data  [NDUT];
    logic [4:0]  o_rd    [NDUT];
    logic [2:0]  o_occ   [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [$clog2(g+3)-1:0] w_occ;
        pipe_stage_reg #(
            .DATA_W (64),
            .CTRL_W (2),
            .RD_W   (5),
            .DEPTH  (g + 1)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst_i),
            .valid_i (valid_i),
            .ready_o (o_ready[g]),
            .ctrl_i  (ctrl_i),
            .data_i  (data_i),
            .rd_i    (rd_i),
            .flush_i (flush_i),
            .valid_o (o_valid[g]),
            .ready_i (ready_i),
            .ctrl_o  (o_ctrl[g]),
            .data_o  (o_data[g]),
            .rd_o    (o_rd[g]),
            .occ_o   (w_occ)
        );
        assign o_occ[g] = 3'(w_occ);
    end

    // Model: per DUT an ordered list of entries (oldest first), each with a position.
    // pos -1 is the skid entry, pos D-1 the output slot; moving to pos D means delivered.
    typedef struct {
        logic [1:0]  ctrl;
        logic [63:0] data;
        logic [4:0]  rd;
        int          pos;
    } ent_t;

    ent_t        ent [NDUT][6];
    int          cnt [NDUT];
    logic [63:0] last_data [NDUT];
    logic [4:0]  last_rd [NDUT];
    bit          live = 0;

    // An entry moves one place forward unless blocked by the (already moved) entry ahead.
    function automatic int newpos(int d, int i);
        int lim = ready_i ? d + 2 : d + 1;
        int p;
        for (int j = 0; j <= i; j++) begin
            p = ent[d][j].pos + 1;
            if (p > lim - 1) p = lim - 1;
            lim = p;
        end
        return lim;
    endfunction

    function automatic bit exp_ready(int d);
`ifdef PIPE_SKID_EN
        return !(cnt[d] > 0 && ent[d][cnt[d]-1].pos < 0);
`else
        return cnt[d] == 0 || newpos(d, cnt[d] - 1) > 0;
`endif
    endfunction

    function automatic void model_step(int d);
        ent_t nq [6];
        int   nn = 0;
        int   np;
        bit   rdy;
        ent_t e;
        if (rst_i) begin
            cnt[d] = 0;
            last_data[d] = '0;
            last_rd[d] = '0;
            return;
        end
        rdy = exp_ready(d);
        if (flush_i) begin
            cnt[d] = 0;
            return;
        end
        for (int i = 0; i < cnt[d]; i++) begin
            np = newpos(d, i);
            if (np <= d) begin
                if (np == d && ent[d][i].pos != d) begin
                    last_data[d] = ent[d][i].data;
                    last_rd[d] = ent[d][i].rd;
                end
                nq[nn] = ent[d][i];
                nq[nn].pos = np;
                nn++;
            end
        end
        if (valid_i && rdy) begin
            e.ctrl = ctrl_i;
            e.data = data_i;
            e.rd = rd_i;
            e.pos = 0;
`ifdef PIPE_SKID_EN
            if (nn > 0 && nq[nn-1].pos == 0) e.pos = -1;
`endif
            if (e.pos == d) begin
                last_data[d] = e.data;
                last_rd[d] = e.rd;
            end
            nq[nn] = e;
            nn++;
        end
        for (int i = 0; i < nn; i++) ent[d][i] = nq[i];
        cnt[d] = nn;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) model_step(d);
        if (rst_i) live = 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit ev;
        #2;
        if (live) begin
            for (int d = 0; d < NDUT; d++) begin
                ev = cnt[d] > 0 && ent[d][0].pos == d;
                chk($sformatf("D%0d valid_o", d+1), 64'(o_valid[d]), 64'(ev));
                chk($sformatf("D%0d ctrl_o", d+1), 64'(o_ctrl[d]), ev ? 64'(ent[d][0].ctrl) : 64'd0);
                chk($sformatf("D%0d data_o", d+1), o_data[d], last_data[d]);
                chk($sformatf("D%0d rd_o", d+1), 64'(o_rd[d]), 64'(last_rd[d]));
                chk($sformatf("D%0d occ_o", d+1), 64'(o_occ[d]), 64'(cnt[d]));
                chk($sformatf("D%0d ready_o", d+1), 64'(o_ready[d]), 64'(exp_ready(d)));
            end
        end
    end

    // Applies inputs just after the falling edge; returns once outputs have settled.
    task automatic drive(input logic v, input logic [1:0] c, input logic [63:0] dt,
                         input logic [4:0] r, input logic rdy, input logic fl, input logic rs);
        @(negedge clk);
        valid_i = v;
        ctrl_i  = c;
        data_i  = dt;
        rd_i    = r;
        ready_i = rdy;
        flush_i = fl;
        rst_i   = rs;
        #2;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        pipe_ctrl_t pc;
        int vprob;
        int rprob;
        pc.regwrite = 1'b1;
        pc.memtoreg = 1'b1;

        // DEPTH=1 streaming: one-cycle latency, occupancy 1
        do_reset();
        drive(1'b1, pc, 64'hDEAD_BEEF_0000_0001, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("T1 reset valid_o", 64'(o_valid[0]), 64'd0);
        chk("T1 reset ready_o", 64'(o_ready[0]), 64'd1);
        drive(1'b1, pc, 64'hDEAD_BEEF_0000_0001, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("T1 valid_o", 64'(o_valid[0]), 64'd1);
        chk("T1 ctrl_o", 64'(o_ctrl[0]), 64'd3);
        chk("T1 data_o", o_data[0], 64'hDEAD_BEEF_0000_0001);
        chk("T1 rd_o", 64'(o_rd[0]), 64'd7);
        chk("T1 occ_o", 64'(o_occ[0]), 64'd1);

        // DEPTH=3: fill, stall four cycles, release in order
        do_reset();
        drive(1'b1, 2'b01, 64'h11, 5'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 64'h22, 5'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 64'h33, 5'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            chk("T2 stall data_o", o_data[2], 64'h11);
            chk("T2 stall occ_o", 64'(o_occ[2]), 64'd3);
`ifndef PIPE_SKID_EN
            chk("T2 stall ready_o", 64'(o_ready[2]), 64'd0);
`endif
        end
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T2 out1", o_data[2], 64'h11);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T2 out2", o_data[2], 64'h22);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T2 out3", o_data[2], 64'h33);
        chk("T2 out3 valid", 64'(o_valid[2]), 64'd1);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T2 drained", 64'(o_valid[2]), 64'd0);

        // DEPTH=2 bubble: stale ctrl 2'b11 must not show
        do_reset();
        drive(1'b1, 2'b11, 64'hA1, 5'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2'b11, 64'hB2, 5'd2, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 64'hC3, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("T3 first valid", 64'(o_valid[1]), 64'd1);
        chk("T3 first data", o_data[1], 64'hA1);
        drive(1'b0, 2'b11, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T3 bubble valid", 64'(o_valid[1]), 64'd0);
        chk("T3 bubble ctrl", 64'(o_ctrl[1]), 64'd0);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T3 third data", o_data[1], 64'hC3);

        // DEPTH=2 full chain flushed together with an incoming entry
        do_reset();
        drive(1'b1, 2'b01, 64'h101, 5'd4, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 64'h202, 5'd5, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 64'h303, 5'd6, 1'b0, 1'b1, 1'b0);
        chk("T4 full occ", 64'(o_occ[1]), 64'd2);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T4 flush valid", 64'(o_valid[1]), 64'd0);
        chk("T4 flush occ", 64'(o_occ[1]), 64'd0);
        chk("T4 flush ready", 64'(o_ready[1]), 64'd1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
            chk("T4 no ghost", 64'(o_valid[1]), 64'd0);
        end

        // Reset in the middle of a stall with two entries held
        do_reset();
        drive(1'b1, 2'b11, 64'h5A5A, 5'd9, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 64'h6B6B, 5'd10, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("T5 occ before", 64'(o_occ[1]), 64'd2);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("T5 valid", 64'(o_valid[1]), 64'd0);
        chk("T5 ctrl", 64'(o_ctrl[1]), 64'd0);
        chk("T5 data", o_data[1], 64'd0);
        chk("T5 rd", 64'(o_rd[1]), 64'd0);
        chk("T5 occ", 64'(o_occ[1]), 64'd0);

`ifdef PIPE_SKID_EN
        // DEPTH=1 with skid: one extra entry taken, then ready_o drops
        do_reset();
        drive(1'b1, 2'b01, 64'hAAAA, 5'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 64'hBBBB, 5'd2, 1'b0, 1'b0, 1'b0);
        chk("T6 ready before skid", 64'(o_ready[0]), 64'd1);
        drive(1'b1, 2'b11, 64'hCCCC, 5'd3, 1'b0, 1'b0, 1'b0);
        chk("T6 ready full", 64'(o_ready[0]), 64'd0);
        chk("T6 occ full", 64'(o_occ[0]), 64'd2);
        drive(1'b1, 2'b11, 64'hCCCC, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("T6 first out", o_data[0], 64'hAAAA);
        chk("T6 ready draining", 64'(o_ready[0]), 64'd0);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T6 second out", o_data[0], 64'hBBBB);
        chk("T6 ready back", 64'(o_ready[0]), 64'd1);
        chk("T6 occ one", 64'(o_occ[0]), 64'd1);
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("T6 no third", 64'(o_valid[0]), 64'd0);
`endif

        // Randomized traffic with shifting valid/ready densities
        vprob = 70;
        rprob = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                vprob = int'($urandom_range(100, 10));
                rprob = int'($urandom_range(100, 10));
            end
            drive(int'($urandom_range(99)) < vprob, 2'($urandom),
                  {$urandom, $urandom}, 5'($urandom),
                  int'($urandom_range(99)) < rprob,
                  $urandom_range(99) < 2, $urandom_range(399) == 0);
        end
        drive(1'b0, 2'b00, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
